simt_core_ctrl: RTL and testbench

- Parametrised sequencing controller for a SIMT compute core: fetch/decode/execute/writeback FSM, PC, and per-thread active mask.
- Adds branch divergence/reconvergence via a mask stack and completes memory ops once only the active threads' LSUs are done.
- Adds a memory-wait timeout and sticky error flags.
- Sits between the fetch/decoder front end and the per-thread register/ALU/LSU lanes.

---
 rtl/simt_core_ctrl_pkg.sv | 31 +++
 rtl/simt_div_stack.sv | 80 ++++++++
 rtl/simt_core_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_simt_core_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simt_core_ctrl_pkg.sv
// Shared types for the SIMT core sequencing controller: state encoding,
// divergence-stack entry layout and the per-lane branch predicate.
`define SIMT_STACK_ENTRY_T(LANES, PCW) \
   struct packed { \
      logic [(LANES)-1:0] saved_mask; \
      logic [(PCW)-1:0]   pend_pc; \
      logic [(LANES)-1:0] pend_mask; \
      logic               phase; \
   }

package simt_core_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      DECODE    = 3'd2,
      EXECUTE   = 3'd3,
      WRITEBACK = 3'd4,
      HALT      = 3'd5
   } core_state_t;

   localparam int NZP_W = 3;

   function automatic logic lane_taken(
      input logic [NZP_W-1:0] lane_nzp,
      input logic [NZP_W-1:0] cond
   );
      return |(lane_nzp & cond);
   endfunction

endpackage

// File: rtl/simt_div_stack.sv
// Divergence/reconvergence mask stack: push a new entry, pop the top,
// or flip the top entry into its second (not-taken) phase.
module simt_div_stack #(
   parameter int LANES = 4,
   parameter int PCW   = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic             set_phase,
   input  logic [LANES-1:0] push_saved,
   input  logic [PCW-1:0]   push_pc,
   input  logic [LANES-1:0] push_pend,
   output logic [LANES-1:0] top_saved,
   output logic [PCW-1:0]   top_pc,
   output logic [LANES-1:0] top_pend,
   output logic             top_phase,
   output logic             full,
   output logic             empty
);
   import simt_core_ctrl_pkg::*;

   localparam int CW = $clog2(DEPTH + 1);

   typedef `SIMT_STACK_ENTRY_T(LANES, PCW) stack_entry_t;

   stack_entry_t  ent_q [DEPTH];
   stack_entry_t  ent_d [DEPTH];
   stack_entry_t  top_e;
   logic [CW-1:0] cnt_q, cnt_d;

   assign full      = (cnt_q == CW'(DEPTH));
   assign empty     = (cnt_q == '0);
   assign top_saved = top_e.saved_mask;
   assign top_pc    = top_e.pend_pc;
   assign top_pend  = top_e.pend_mask;
   assign top_phase = top_e.phase;

   always_comb begin
      ent_d = ent_q;
      cnt_d = cnt_q;
      top_e = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (cnt_q == CW'(i + 1)) top_e = ent_q[i];
      end
      if (clear) begin
         cnt_d = '0;
      end else if (push && !full) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (cnt_q == CW'(i)) begin
               ent_d[i].saved_mask = push_saved;
               ent_d[i].pend_pc    = push_pc;
               ent_d[i].pend_mask  = push_pend;
               ent_d[i].phase      = 1'b0;
            end
         end
         cnt_d = cnt_q + 1'b1;
      end else if (pop && !empty) begin
         cnt_d = cnt_q - 1'b1;
      end else if (set_phase && !empty) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (cnt_q == CW'(i + 1)) ent_d[i].phase = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      end else begin
         cnt_q <= cnt_d;
         ent_q <= ent_d;
      end
   end

endmodule

// File: rtl/simt_core_ctrl.sv
// SIMT core sequencer: fetch/decode/execute/writeback FSM, PC, active mask,
// branch divergence via a mask stack, LSU wait timeout and sticky errors.
module simt_core_ctrl
   import simt_core_ctrl_pkg::*;
#(
   parameter int THREADS_PER_BLOCK     = 4,
   parameter int PROGRAM_MEM_ADDR_BITS = 8,
   parameter int STACK_DEPTH           = 4,
   parameter int MEM_TIMEOUT           = 255
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count,
   input  logic                                 fetch_done,
   input  logic                                 is_branch,
   input  logic                                 is_sync,
   input  logic                                 is_ldr,
   input  logic                                 is_str,
   input  logic                                 is_halt,
   input  logic [2:0]                           condition,
   input  logic [PROGRAM_MEM_ADDR_BITS-1:0]     branch_target,
   input  logic [THREADS_PER_BLOCK*3-1:0]       nzp,
   input  logic [THREADS_PER_BLOCK-1:0]         lsu_done,
   output core_state_t                          core_state,
   output logic                                 fetch_enable,
   output logic [PROGRAM_MEM_ADDR_BITS-1:0]     pc,
   output logic [THREADS_PER_BLOCK-1:0]         active_mask,
   output logic [THREADS_PER_BLOCK-1:0]         wb_enable,
   output logic                                 done,
   output logic                                 err_overflow,
   output logic                                 err_timeout
);

   localparam int T   = THREADS_PER_BLOCK;
   localparam int PCW = PROGRAM_MEM_ADDR_BITS;
   localparam int TOW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   core_state_t    state_q, state_d;
   logic [PCW-1:0] pc_q, pc_d;
   logic [T-1:0]   mask_q, mask_d;
   logic           done_q, done_d;
   logic           ov_q, ov_d;
   logic           to_q, to_d;
   logic [TOW-1:0] tmo_q, tmo_d;

   logic [T-1:0]   init_mask;
   logic [T-1:0]   taken;
   logic [PCW-1:0] pc_inc;
   logic           mem_op, mem_ok, br_op, sync_op;
   logic           st_clear, st_push, st_pop, st_phase;
   logic [T-1:0]   top_saved, top_pend;
   logic [PCW-1:0] top_pc;
   logic           top_phase, st_full, st_empty;

   // halt overrides any other decoded flag
   assign mem_op  = (is_ldr | is_str) & ~is_halt;
   assign br_op   = is_branch & ~is_halt;
   assign sync_op = is_sync & ~is_halt & ~is_branch;
   assign mem_ok  = ((lsu_done & mask_q) == mask_q);
   assign pc_inc  = pc_q + 1'b1;

   always_comb begin
      init_mask = '0;
      taken     = '0;
      for (int i = 0; i < T; i++) begin
         init_mask[i] = (int'(thread_count) > i);
         taken[i]     = mask_q[i] &
                        lane_taken(nzp[i*NZP_W +: NZP_W], condition);
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      mask_d   = mask_q;
      done_d   = done_q;
      ov_d     = ov_q;
      to_d     = to_q;
      tmo_d    = tmo_q;
      st_clear = 1'b0;
      st_push  = 1'b0;
      st_pop   = 1'b0;
      st_phase = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               pc_d     = '0;
               mask_d   = init_mask;
               done_d   = 1'b0;
               ov_d     = 1'b0;
               to_d     = 1'b0;
               st_clear = 1'b1;
               state_d  = FETCH;
            end
         end
         FETCH: begin
            if (fetch_done) state_d = DECODE;
         end
         DECODE: begin
            tmo_d   = '0;
            state_d = EXECUTE;
         end
         EXECUTE: begin
            if (!mem_op || mem_ok) begin
               state_d = WRITEBACK;
            end else begin
               tmo_d = tmo_q + 1'b1;
               if (MEM_TIMEOUT != 0 && tmo_d == TOW'(MEM_TIMEOUT)) begin
                  to_d    = 1'b1;
                  state_d = WRITEBACK;
               end
            end
         end
         WRITEBACK: begin
            pc_d    = pc_inc;
            state_d = is_halt ? HALT : FETCH;
            if (br_op) begin
               if (taken == mask_q) begin
                  pc_d = branch_target;
               end else if (taken != '0) begin
                  pc_d = branch_target;
                  if (st_full) begin
                     ov_d = 1'b1;
                  end else begin
                     st_push = 1'b1;
                     mask_d  = taken;
                  end
               end
            end else if (sync_op && !st_empty) begin
               if (!top_phase) begin
                  st_phase = 1'b1;
                  mask_d   = top_pend;
                  pc_d     = top_pc;
               end else begin
                  st_pop = 1'b1;
                  mask_d = top_saved;
               end
            end
         end
         HALT: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         mask_q  <= '0;
         done_q  <= 1'b0;
         ov_q    <= 1'b0;
         to_q    <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         mask_q  <= mask_d;
         done_q  <= done_d;
         ov_q    <= ov_d;
         to_q    <= to_d;
         tmo_q   <= tmo_d;
      end
   end

   simt_div_stack #(
      .LANES (T),
      .PCW   (PCW),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk        (clk),
      .reset      (reset),
      .clear      (st_clear),
      .push       (st_push),
      .pop        (st_pop),
      .set_phase  (st_phase),
      .push_saved (mask_q),
      .push_pc    (pc_inc),
      .push_pend  (mask_q & ~taken),
      .top_saved  (top_saved),
      .top_pc     (top_pc),
      .top_pend   (top_pend),
      .top_phase  (top_phase),
      .full       (st_full),
      .empty      (st_empty)
   );

   assign core_state   = state_q;
   assign fetch_enable = (state_q == FETCH);
   assign pc           = pc_q;
   assign active_mask  = mask_q;
   assign wb_enable    = (state_q == WRITEBACK) ? mask_q : '0;
   assign done         = done_q;
   assign err_overflow = ov_q;
   assign err_timeout  = to_q;

endmodule

// File: tb/tb_simt_core_ctrl.sv
// Randomized scoreboard bench for simt_core_ctrl: a front-end driver issues
// random instructions, a reference model predicts each writeback's outcome.
module tb_simt_core_ctrl;
   import simt_core_ctrl_pkg::*;

   localparam int T   = 4;
   localparam int PCW = 8;
   localparam int SD  = 2;
   localparam int MT  = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [2:0]     thread_count;
   logic           fetch_done;
   logic           is_branch, is_sync, is_ldr, is_str, is_halt;
   logic [2:0]     condition;
   logic [PCW-1:0] branch_target;
   logic [T*3-1:0] nzp;
   logic [T-1:0]   lsu_done;
   core_state_t    core_state;
   logic           fetch_enable;
   logic [PCW-1:0] pc;
   logic [T-1:0]   active_mask;
   logic [T-1:0]   wb_enable;
   logic           done;
   logic           err_overflow;
   logic           err_timeout;

   always #5 clk = ~clk;

   simt_core_ctrl #(
      .THREADS_PER_BLOCK     (T),
      .PROGRAM_MEM_ADDR_BITS (PCW),
      .STACK_DEPTH           (SD),
      .MEM_TIMEOUT           (MT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .thread_count  (thread_count),
      .fetch_done    (fetch_done),
      .is_branch     (is_branch),
      .is_sync       (is_sync),
      .is_ldr        (is_ldr),
      .is_str        (is_str),
      .is_halt       (is_halt),
      .condition     (condition),
      .branch_target (branch_target),
      .nzp           (nzp),
      .lsu_done      (lsu_done),
      .core_state    (core_state),
      .fetch_enable  (fetch_enable),
      .pc            (pc),
      .active_mask   (active_mask),
      .wb_enable     (wb_enable),
      .done          (done),
      .err_overflow  (err_overflow),
      .err_timeout   (err_timeout)
   );

   typedef struct {
      logic [T-1:0]   wb;
      int             cyc;
      logic [PCW-1:0] pc;
      logic [T-1:0]   mask;
      logic           ov;
      logic           to;
      logic           hlt;
   } exp_t;

   typedef struct {
      logic [T-1:0]   saved;
      logic [PCW-1:0] ppc;
      logic [T-1:0]   pend;
      logic           ph;
   } ment_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   kdone = 0;
   logic mon_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // monitor: pops one expectation per WRITEBACK cycle
   exp_t cur;
   logic pend_post = 1'b0;
   logic pend_done = 1'b0;
   int   exe_cnt = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (pend_done) begin
            pend_done = 1'b0;
            chk("done_after_halt", 32'(done), 32'(1));
            chk("idle_after_halt", 32'(core_state), 32'(IDLE));
         end
         if (pend_post) begin
            pend_post = 1'b0;
            chk("pc", 32'(pc), 32'(cur.pc));
            chk("mask", 32'(active_mask), 32'(cur.mask));
            chk("err_overflow", 32'(err_overflow), 32'(cur.ov));
            chk("err_timeout", 32'(err_timeout), 32'(cur.to));
            chk("state_after_wb", 32'(core_state),
                cur.hlt ? 32'(HALT) : 32'(FETCH));
            if (cur.hlt) pend_done = 1'b1;
         end
         if (core_state != WRITEBACK)
            chk("wb_outside_writeback", 32'(wb_enable), 32'(0));
         if (core_state == EXECUTE) begin
            exe_cnt++;
         end else if (core_state == WRITEBACK) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_underflow: writeback with no expected entry");
            end else begin
               cur = sb.pop_front();
               chk("wb_enable", 32'(wb_enable), 32'(cur.wb));
               chk("exec_cycles", 32'(exe_cnt), 32'(cur.cyc));
               pend_post = 1'b1;
            end
            exe_cnt = 0;
         end else begin
            exe_cnt = 0;
         end
      end
   end

   task automatic run_kernel(input logic [2:0] tc);
      logic [T-1:0]   m_mask, act, tk, noise, part;
      logic [PCW-1:0] m_pc, nxt;
      logic           m_ov, m_to, hang, issued_halt, mem;
      ment_t          mst[$];
      ment_t          e;
      exp_t           x;
      int             n, guard, fdel, k, d, r;
      chk("done_hold_idle", 32'(done), 32'(kdone > 0));
      thread_count = tc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      m_mask = '0;
      for (int l = 0; l < T; l++) if (l < int'(tc)) m_mask[l] = 1'b1;
      m_pc = '0;
      m_ov = 1'b0;
      m_to = 1'b0;
      act = '0;
      hang = 1'b0;
      issued_halt = 1'b0;
      n = 0;
      k = 0;
      d = 0;
      guard = 0;
      chk("start_state", 32'(core_state), 32'(FETCH));
      chk("start_fetch_en", 32'(fetch_enable), 32'(1));
      chk("start_pc", 32'(pc), 32'(0));
      chk("start_mask", 32'(active_mask), 32'(m_mask));
      chk("start_done", 32'(done), 32'(0));
      chk("start_errs", 32'({err_overflow, err_timeout}), 32'(0));
      fdel = $urandom_range(0, 2);
      while (guard < 3000) begin
         guard++;
         if (core_state == IDLE && issued_halt) break;
         start = (core_state != IDLE) && ($urandom_range(0, 7) == 0);
         fetch_done = 1'b0;
         if (core_state == FETCH) begin
            if (fdel > 0) begin
               fdel--;
            end else begin
               r = $urandom_range(0, 99);
               is_branch = (r < 30);
               is_sync   = (r >= 30 && r < 45);
               is_ldr    = (r >= 45 && r < 60);
               is_str    = (r >= 60 && r < 70);
               is_halt   = (n >= 40) || ($urandom_range(0, 24) == 0);
               condition = 3'($urandom);
               nzp = 12'($urandom);
               branch_target = 8'($urandom);
               hang = ($urandom_range(0, 3) == 0);
               d = $urandom_range(0, 6);
               k = 0;
               n++;
               act = m_mask;
               x.wb = act;
               x.cyc = 1;
               x.hlt = is_halt;
               mem = (is_ldr || is_str) && !is_halt;
               if (mem && act != '0) begin
                  if (hang) begin
                     x.cyc = MT;
                     m_to = 1'b1;
                  end else begin
                     x.cyc = d + 1;
                  end
               end
               nxt = m_pc + 8'd1;
               if (is_halt) begin
                  m_pc = nxt;
               end else if (is_branch) begin
                  tk = '0;
                  for (int l = 0; l < T; l++)
                     if ((nzp[3*l +: 3] & condition) != 3'b000) tk[l] = act[l];
                  if (tk == act) begin
                     m_pc = branch_target;
                  end else if (tk == '0) begin
                     m_pc = nxt;
                  end else begin
                     m_pc = branch_target;
                     if (mst.size() >= SD) begin
                        m_ov = 1'b1;
                     end else begin
                        e.saved = act;
                        e.ppc = nxt;
                        e.pend = act & ~tk;
                        e.ph = 1'b0;
                        mst.push_back(e);
                        m_mask = tk;
                     end
                  end
               end else if (is_sync) begin
                  if (mst.size() == 0) begin
                     m_pc = nxt;
                  end else begin
                     e = mst.pop_back();
                     if (!e.ph) begin
                        e.ph = 1'b1;
                        mst.push_back(e);
                        m_mask = e.pend;
                        m_pc = e.ppc;
                     end else begin
                        m_mask = e.saved;
                        m_pc = nxt;
                     end
                  end
               end else begin
                  m_pc = nxt;
               end
               x.pc = m_pc;
               x.mask = m_mask;
               x.ov = m_ov;
               x.to = m_to;
               sb.push_back(x);
               if (is_halt) issued_halt = 1'b1;
               fetch_done = 1'b1;
               fdel = $urandom_range(0, 2);
            end
         end else if (core_state == EXECUTE) begin
            noise = 4'($urandom);
            if (!hang && k >= d) begin
               lsu_done = noise | act;
            end else begin
               part = noise & act;
               if (part == act && act != '0) part = part & (part - 4'd1);
               lsu_done = (noise & ~act) | part;
            end
            k++;
         end
         @(negedge clk);
      end
      start = 1'b0;
      fetch_done = 1'b0;
      if (guard >= 3000) begin
         checks++;
         failures++;
         $display("FAIL kernel_timeout: no return to IDLE after halt");
      end
      kdone++;
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      thread_count = '0;
      fetch_done = 1'b0;
      is_branch = 1'b0;
      is_sync = 1'b0;
      is_ldr = 1'b0;
      is_str = 1'b0;
      is_halt = 1'b0;
      condition = '0;
      branch_target = '0;
      nzp = '0;
      lsu_done = '0;
      repeat (2) @(negedge clk);
      chk("rst_state", 32'(core_state), 32'(IDLE));
      chk("rst_pc", 32'(pc), 32'(0));
      chk("rst_mask", 32'(active_mask), 32'(0));
      chk("rst_wb", 32'(wb_enable), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_errs", 32'({err_overflow, err_timeout}), 32'(0));
      chk("rst_fetch_en", 32'(fetch_enable), 32'(0));
      reset = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      run_kernel(3'd3);
      run_kernel(3'd0);
      run_kernel(3'd7);
      for (int i = 0; i < 40; i++) run_kernel(3'($urandom_range(0, 7)));
      @(negedge clk);
      mon_en = 1'b0;
      chk("sb_drained", 32'(sb.size()), 32'(0));

      thread_count = 3'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      is_branch = 1'b0;
      is_sync = 1'b0;
      is_halt = 1'b0;
      is_str = 1'b0;
      is_ldr = 1'b1;
      lsu_done = '0;
      fetch_done = 1'b1;
      @(negedge clk);
      fetch_done = 1'b0;
      @(negedge clk);
      chk("pre_reset_execute", 32'(core_state), 32'(EXECUTE));
      chk("pre_reset_mask", 32'(active_mask), 32'(4'b1111));
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("mid_rst_state", 32'(core_state), 32'(IDLE));
      chk("mid_rst_pc", 32'(pc), 32'(0));
      chk("mid_rst_mask", 32'(active_mask), 32'(0));
      chk("mid_rst_done", 32'(done), 32'(0));
      chk("mid_rst_wb", 32'(wb_enable), 32'(0));
      chk("mid_rst_errs", 32'({err_overflow, err_timeout}), 32'(0));
      @(negedge clk);
      chk("mid_rst_stay_idle", 32'(core_state), 32'(IDLE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
